// File: rtl/alu_link_master.sv
// Host-side initiator for the 8-bit ALU pin link: serialises one operation as
// three strobed beats, waits a bounded time for the result, returns it.
module alu_link_master #(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [3:0] HEADER         = 4'h5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [7:0] link_out,
    output logic       link_strobe,
    input  logic [7:0] link_in,
    input  logic       link_rdy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT_OP,
        S_BEAT_A,
        S_BEAT_B,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] wait_cnt;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Each link byte is registered on the edge that enters its beat state, so
    // beat 0 is loaded straight from the request on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and counter registers are reset too; the block is
            // tiny and a fully defined state after reset keeps the link quiet.
            state       <= S_IDLE;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            wait_cnt    <= 8'h00;
            link_out    <= 8'h00;
            link_strobe <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the register values from before this edge.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        link_out    <= {HEADER, req_op};
                        link_strobe <= 1'b1;
                        state       <= S_BEAT_OP;
                    end
                end
                S_BEAT_OP: begin
                    link_out <= a_q;
                    state    <= S_BEAT_A;
                end
                S_BEAT_A: begin
                    link_out <= b_q;
                    state    <= S_BEAT_B;
                end
                S_BEAT_B: begin
                    link_out    <= 8'h00;
                    link_strobe <= 1'b0;
                    wait_cnt    <= 8'h00;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready flag on the final allowed cycle beats the timeout.
                    if (link_rdy) begin
                        rsp_data    <= link_in;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_data    <= 8'h00;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_link_master.sv
// Directed-vector bench for alu_link_master; one instance with a short
// timeout so the timeout and ready-vs-timeout boundary stay cheap to reach.
module tb_alu_link_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] link_out;
    logic       link_strobe;
    logic [7:0] link_in;
    logic       link_rdy;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_link_master #(.TIMEOUT_CYCLES(4), .HEADER(4'h5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .link_out    (link_out),
        .link_strobe (link_strobe),
        .link_in     (link_in),
        .link_rdy    (link_rdy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in an IDLE cycle; returns in cycle 1 (BEAT_OP).
    task automatic send_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_beats(input string tag, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
        check({tag, "_beat0"}, {link_strobe, link_out}, {1'b1, b0});
        tick();
        check({tag, "_beat1"}, {link_strobe, link_out}, {1'b1, b1});
        tick();
        check({tag, "_beat2"}, {link_strobe, link_out}, {1'b1, b2});
        tick();
        check({tag, "_wait_idle_link"}, {link_strobe, link_out}, 9'h000);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_link"}, {link_strobe, link_out}, 9'h000);
        check({tag, "_rsp"}, {rsp_valid, rsp_timeout, rsp_data}, 10'h000);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_ready_after_hs"}, {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        link_in   = 8'h00;
        link_rdy  = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Basic op, ready in the 3rd WAIT cycle (cycle 6) -> rsp_valid cycle 7.
        send_req(4'h1, 8'h03, 8'h04);
        check("t1_busy", busy, 1);
        check_beats("t1", 8'h51, 8'h03, 8'h04);
        tick();
        tick();
        check("t1_no_early_rsp", rsp_valid, 0);
        link_rdy = 1'b1;
        link_in  = 8'h07;
        tick();
        link_rdy = 1'b0;
        check("t1_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h07});
        handshake("t1");

        // Back-pressure: response held for 10 cycles with rsp_ready low.
        send_req(4'h1, 8'h03, 8'h04);
        tick(); tick(); tick(); tick(); tick();
        link_rdy = 1'b1;
        link_in  = 8'h07;
        tick();
        link_rdy = 1'b0;
        link_in  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h07});
            check("t2_hold_req_ready", req_ready, 0);
            tick();
        end
        handshake("t2");

        // Timeout: 4 WAIT cycles (4..7), rsp_valid in cycle 8.
        send_req(4'h2, 8'h10, 8'h20);
        check_beats("t3", 8'h52, 8'h10, 8'h20);
        tick(); tick(); tick();
        check("t3_no_early_rsp", rsp_valid, 0);
        tick();
        check("t3_timeout_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b11, 8'h00});
        handshake("t3");
        check("t3_timeout_clears", rsp_timeout, 0);

        // Stale ready during BEAT_A/BEAT_B must be ignored.
        send_req(4'h3, 8'h11, 8'h22);
        tick();
        link_rdy = 1'b1;
        link_in  = 8'hAA;
        check("t4_beat1", link_out, 8'h11);
        tick();
        tick();
        link_rdy = 1'b0;
        tick();
        check("t4_stale_ignored", rsp_valid, 0);
        link_rdy = 1'b1;
        link_in  = 8'h3C;
        tick();
        link_rdy = 1'b0;
        check("t4_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h3C});
        handshake("t4");

        // Ready on the last allowed WAIT cycle wins over timeout.
        send_req(4'h6, 8'h01, 8'h02);
        tick(); tick(); tick(); tick(); tick(); tick();
        check("t5_no_early_rsp", rsp_valid, 0);
        link_rdy = 1'b1;
        link_in  = 8'h5A;
        tick();
        link_rdy = 1'b0;
        check("t5_rdy_beats_timeout", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h5A});
        handshake("t5");

        // Reset in the 2nd WAIT cycle discards the operation.
        send_req(4'h7, 8'h33, 8'h44);
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        tick();
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen_valid++;
            tick();
        end
        check("t6_no_rsp_after_reset", seen_valid, 0);
        send_req(4'h1, 8'h03, 8'h04);
        check_beats("t6_after", 8'h51, 8'h03, 8'h04);
        link_rdy = 1'b1;
        link_in  = 8'h07;
        tick();
        link_rdy = 1'b0;
        check("t6_min_round_trip", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h07});
        handshake("t6");

        // Back-to-back with rsp_ready tied high.
        rsp_ready = 1'b1;
        req_op    = 4'h4;
        req_a     = 8'h01;
        req_b     = 8'h02;
        req_valid = 1'b1;
        tick();
        req_op = 4'h5;
        req_a  = 8'h10;
        req_b  = 8'h20;
        check("t7_a_beat0", {link_strobe, link_out}, {1'b1, 8'h54});
        tick();
        check("t7_a_beat1", link_out, 8'h01);
        tick();
        check("t7_a_beat2", link_out, 8'h02);
        tick();
        link_rdy = 1'b1;
        link_in  = 8'hF0;
        tick();
        link_rdy = 1'b0;
        check("t7_a_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'hF0});
        tick();
        check("t7_idle_gap", {req_ready, link_strobe, rsp_valid}, 3'b100);
        tick();
        req_valid = 1'b0;
        check("t7_b_beat0", {link_strobe, link_out}, {1'b1, 8'h55});
        tick();
        check("t7_b_beat1", link_out, 8'h10);
        tick();
        check("t7_b_beat2", link_out, 8'h20);
        tick();
        link_rdy = 1'b1;
        link_in  = 8'h0F;
        tick();
        link_rdy = 1'b0;
        check("t7_b_rsp", {rsp_valid, rsp_timeout, rsp_data}, {2'b10, 8'h0F});
        tick();
        check("t7_b_done", {req_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
